// File: rtl/dma_controller.sv
// Single-channel device-to-memory DMA engine: requests the bus, then reads a device word and writes it to memory, once per word.
// Optional cycle stealing is enabled by defining DMA_CYCLE_STEAL_EN; it releases the bus for one cycle after every 4 words.
module dma_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd,
  input  logic [15:0] base_addr,
  input  logic [3:0]  length,
  output logic        BR,
  input  logic        BG,
  output logic        use_bus,
  output logic [3:0]  idx,
  input  logic [15:0] dev_data,
  output logic        m_write,
  output logic [15:0] m_addr,
  output logic [15:0] m_data,
  input  logic        m_ack,
  output logic        dma_end,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    READ    = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [15:0] base_q;
  logic [3:0]  len_q;
  logic [3:0]  count;
  logic [15:0] data_q;
  logic [3:0]  len_clamp;
  logic [3:0]  count_inc;
  logic        steal;

  assign len_clamp = (length > 4'd12) ? 4'd12 : length;
  assign count_inc = count + 4'd1;

`ifdef DMA_CYCLE_STEAL_EN
  // count_inc is never 0 here, so a zero low pair means a nonzero multiple of 4.
  assign steal = (count_inc[1:0] == 2'b00);
`else
  assign steal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      base_q <= 16'h0000;
      len_q  <= 4'd0;
      count  <= 4'd0;
      data_q <= 16'h0000;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cmd) begin
            base_q <= base_addr;
            len_q  <= len_clamp;
            count  <= 4'd0;
          end
        end
        READ:    data_q <= dev_data;
        WRITE:   if (m_ack) count <= count_inc;
        default: ;
      endcase
    end
  end

  // Memory handshake: m_write/m_addr/m_data are held stable from WRITE entry
  // until the cycle m_ack is sampled high; that edge completes the word.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd) state_nx = (len_clamp == 4'd0) ? DONE : REQ;
      REQ:     if (BG) state_nx = READ;
      READ:    state_nx = WRITE;
      WRITE: begin
        if (m_ack) begin
          if (count_inc == len_q) state_nx = DONE;
          else if (steal)         state_nx = RELEASE;
          else if (!BG)           state_nx = REQ;
          else                    state_nx = READ;
        end
      end
      RELEASE: state_nx = REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BR        = (state == REQ) || (state == READ) || (state == WRITE);
  assign use_bus   = (state == READ);
  assign idx       = use_bus ? count : 4'd0;
  assign m_write   = (state == WRITE);
  assign m_addr    = m_write ? (base_q + {12'h000, count}) : 16'h0000;
  assign m_data    = data_q;
  assign dma_end   = (state == DONE);
  assign fsm_state = state;

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cmd  in  1  start pulse from CPU, sampled when idle.
REQ-004 SHALL have ports: base_addr  in  16  memory destination of word 0, sampled with cmd.
REQ-005 SHALL have ports: length  in  4  words to move, sampled with cmd.
REQ-006 SHALL have ports: BR  out  1  bus request to CPU; BG  in  1  bus grant from CPU.
REQ-007 SHALL have ports: use_bus  out  1  device drive enable; idx  out  4  device word index.
REQ-008 SHALL have ports: dev_data  in  16  device data bus, valid same cycle as use_bus.
REQ-009 SHALL have ports: m_write  out  1; m_addr  out  16; m_data  out  16  memory write request, held until m_ack.
REQ-010 SHALL have ports: m_ack  in  1  memory write complete, one-cycle pulse.
REQ-011 SHALL have ports: dma_end  out  1  one-cycle completion interrupt to CPU.

Function
REQ-012 SHALL implement states IDLE, REQ, READ, WRITE, RELEASE, DONE.
REQ-013 IDLE: cmd=1 latches base_addr, length, clears count to 0; length=0 -> DONE, else -> REQ; cmd in any other state ignored.
REQ-014 length >12 SHALL be clamped to 12 at latch time.
REQ-015 REQ: BR=1; BG=1 -> READ next cycle; waits indefinitely otherwise.
REQ-016 READ (one cycle): use_bus=1, idx=count; dev_data captured into m_data at clock edge; -> WRITE.
REQ-017 WRITE: m_write=1, m_addr=base_addr+count (16-bit wrap-around, no carry out), m_data stable; stays until m_ack.
REQ-018 On m_ack: count increments; count==length -> DONE; else if BG=0 -> REQ; else -> READ (or RELEASE per REQ-027).
REQ-019 BR SHALL stay 1 from REQ entry through the last m_ack, except in RELEASE.
REQ-020 BG dropping during READ/WRITE SHALL NOT abort the current word; re-request happens after its m_ack.
REQ-021 DONE (one cycle): dma_end=1, BR=0, use_bus=0 -> IDLE.
REQ-022 use_bus SHALL be 1 only in READ; m_write only in WRITE; no cycle has both.
REQ-023 Per-word latency with m_ack on first WRITE cycle and BG held: 2 cycles; total for N words: 1 (REQ) + 2N + 1 (DONE).

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, count=0, BR=0, use_bus=0, idx=0, m_write=0, m_addr=0, m_data=0, dma_end=0, independent of clk.
REQ-025 Reset mid-transfer SHALL abandon the transfer without dma_end; words already acknowledged remain written.
REQ-026 First cmd after reset release SHALL be honoured on the first rising edge with reset_n=1.

Configuration
REQ-027 Macro DMA_CYCLE_STEAL_EN defined: after each m_ack where count (post-increment) is a nonzero multiple of 4 and count<length, SHALL enter RELEASE (BR=0 one cycle) then REQ; undefined: RELEASE unreachable, bus held for whole transfer.

Verification
REQ-028 cmd, base_addr=16'h0017, length=12, BG tied 1, m_ack on first WRITE cycle -> memory 0x17..0x22 = 16'h0000..16'hbbbb, dma_end pulses once at cycle 26 after cmd.
REQ-029 length=0 -> BR never asserted, dma_end pulses next cycle after IDLE sample.
REQ-030 base_addr=16'hfffe, length=4 -> m_addr sequence fffe, ffff, 0000, 0001.
REQ-031 BG deasserted during WRITE of word 5, reasserted 3 cycles later -> word 5 completes, controller holds in REQ, resumes at idx=6, no data loss.
REQ-032 reset_n low during WRITE of word 3 -> all outputs 0 within same cycle, no dma_end; subsequent cmd length=2 runs cleanly.
REQ-033 With DMA_CYCLE_STEAL_EN, length=12 -> BR low for exactly one cycle after words 4 and 8, not after 12; without it BR never drops until DONE.
